clock_counter_sequencer: RTL and testbench
==========================================

CLOCK_COUNTER_SEQUENCER -- requirements
Module: clock_counter_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: AXI4-Lite address width.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0: clockCounter register base.
REQ-003 SHALL have parameter POLL_LIMIT, default 1024: max status polls, used only when the timeout feature is compiled in.
REQ-004 SHALL have ports, one per line (name direction width meaning):
- ACLK  in  1  sole clock; all logic on rising edge.
- ARESETN  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle pulse; begins a measurement; ignored unless idle.
- window  in  32  count window length, sampled on accepted start.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at sequence end.
- err  out  1  valid with done; 1 = bus error or timeout.
- count  out  32  measured count, valid with done, held until next done.
- m_axi_awaddr  out  ADDR_W  write address.
- m_axi_awvalid  out  1  write address valid.
- m_axi_awready  in  1  write address ready.
- m_axi_wdata  out  32  write data, strobes all ones, prot 0.
- m_axi_wvalid  out  1  write data valid.
- m_axi_wready  in  1  write data ready.
- m_axi_bresp  in  2  write response.
- m_axi_bvalid  in  1  write response valid.
- m_axi_bready  out  1  write response ready.
- m_axi_araddr  out  ADDR_W  read address.
- m_axi_arvalid  out  1  read address valid.
- m_axi_arready  in  1  read address ready.
- m_axi_rdata  in  32  read data.
- m_axi_rresp  in  2  read response.
- m_axi_rvalid  in  1  read data valid.
- m_axi_rready  out  1  read data ready.

Function
REQ-005 SHALL use clockCounter register map: +0x0 CTRL (bit0 run), +0x4 WINDOW, +0x8 COUNT, +0xC STATUS (bit0 complete).
REQ-006 SHALL implement states IDLE, WR_WIN, WR_RUN, POLL, RD_CNT, FIN.
REQ-007 SHALL go IDLE->WR_WIN on start; busy rises next cycle.
REQ-008 SHALL perform: WR_WIN writes window to +0x4; WR_RUN writes 1 to +0x0; POLL reads +0xC until bit0=1; RD_CNT reads +0x8 into count; FIN pulses done one cycle, returns IDLE.
REQ-009 SHALL have at most one AXI transaction outstanding; no read and write concurrently.
REQ-010 Write: SHALL assert awvalid and wvalid in the same cycle; SHALL hold each independently until its ready is sampled high; SHALL drop each the cycle after its handshake; SHALL raise bready only after both handshakes complete, until bvalid.
REQ-011 Read: SHALL hold arvalid until arready; SHALL raise rready after the AR handshake, until rvalid.
REQ-012 SHALL keep address/data stable while the corresponding valid is high.
REQ-013 Any bresp/rresp != 2'b00 SHALL abort to FIN with err=1; count unchanged.
REQ-014 POLL SHALL insert one idle cycle between consecutive status reads.
REQ-015 start while busy SHALL be ignored; window SHALL be sampled only on accepted start.

Reset
REQ-016 ARESETN low at a rising ACLK edge SHALL force IDLE, all valid/ready outputs 0, busy=0, done=0, err=0, count=0, addresses/wdata=0, poll counter=0.
REQ-017 Reset mid-transaction SHALL abandon it without completing the handshake; no done pulse.

Configuration
REQ-018 Macro CCSEQ_POLL_TIMEOUT_EN defined: SHALL count status reads; after POLL_LIMIT reads without complete, SHALL go FIN with err=1.
REQ-019 Macro undefined: SHALL poll indefinitely; POLL_LIMIT unused; no counter logic.

Verification
REQ-020 window=100, slave always ready, complete on 3rd poll, COUNT=0x64 -> writes 0x64@+0x4, 0x1@+0x0, 3 reads @+0xC, read @+0x8; done with count=0x64, err=0.
REQ-021 awready delayed 4 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held 4; bready only after both handshakes.
REQ-022 bresp=2'b10 on WINDOW write -> no CTRL write, done with err=1, count retains prior value.
REQ-023 start pulsed again during POLL with window=5 -> ignored; completes with original window.
REQ-024 ARESETN low during RD_CNT with arvalid high -> next cycle all outputs 0, IDLE; fresh start runs normally.
REQ-025 CCSEQ_POLL_TIMEOUT_EN, POLL_LIMIT=4, STATUS never complete -> exactly 4 status reads, then done with err=1.

Source files
------------

// File: rtl/clock_counter_sequencer.sv
// clock_counter_sequencer
// Drives a memory-mapped clockCounter peripheral over an AXI4-Lite master port:
// writes the window length, starts the counter, polls STATUS until complete,
// then reads COUNT back and reports it with a one-cycle done pulse.
// Optional build macro: CCSEQ_POLL_TIMEOUT_EN -- when defined, polling gives
// up with err=1 after POLL_LIMIT status reads that never report complete.
`timescale 1ns/1ps

module clock_counter_sequencer #(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter int                POLL_LIMIT = 1024
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic              start,
    input  logic [31:0]       window,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       count,
    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [31:0]       m_axi_wdata,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    input  logic [1:0]        m_axi_bresp,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [31:0]       m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready
);

    // clockCounter register map
    localparam logic [ADDR_W-1:0] ADDR_CTRL   = BASE_ADDR;
    localparam logic [ADDR_W-1:0] ADDR_WINDOW = BASE_ADDR + ADDR_W'(4);
    localparam logic [ADDR_W-1:0] ADDR_COUNT  = BASE_ADDR + ADDR_W'(8);
    localparam logic [ADDR_W-1:0] ADDR_STATUS = BASE_ADDR + ADDR_W'(12);

    // A zero poll limit would make the timeout meaningless; reject it early.
    if (POLL_LIMIT < 1) begin : g_bad_poll_limit
        $error("clock_counter_sequencer: POLL_LIMIT must be at least 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        WR_WIN,
        WR_RUN,
        POLL,
        RD_CNT,
        FIN
    } state_t;

    state_t            state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [31:0]       count_q, count_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d;
    logic              awvalid_q, awvalid_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              wvalid_q, wvalid_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic              bready_q, bready_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q, rready_d;
    logic              poll_gap_q, poll_gap_d;

`ifdef CCSEQ_POLL_TIMEOUT_EN
    localparam int             PC_W    = $clog2(POLL_LIMIT + 1);
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(POLL_LIMIT - 1);
    logic [PC_W-1:0] poll_cnt_q, poll_cnt_d;
`endif

    // Handshake strobes for the current cycle.
    logic aw_fire, w_fire, b_fire, ar_fire, r_fire;
    assign aw_fire = awvalid_q & m_axi_awready;
    assign w_fire  = wvalid_q  & m_axi_wready;
    assign b_fire  = bready_q  & m_axi_bvalid;
    assign ar_fire = arvalid_q & m_axi_arready;
    assign r_fire  = rready_q  & m_axi_rvalid;

    // Next-state and registered-output computation for the sequencer.
    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;
        count_d    = count_q;
        awaddr_d   = awaddr_q;
        awvalid_d  = awvalid_q;
        wdata_d    = wdata_q;
        wvalid_d   = wvalid_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        bready_d   = bready_q;
        araddr_d   = araddr_q;
        arvalid_d  = arvalid_q;
        rready_d   = rready_q;
        poll_gap_d = poll_gap_q;
`ifdef CCSEQ_POLL_TIMEOUT_EN
        poll_cnt_d = poll_cnt_q;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    // Window is captured straight into the write data register.
                    state_d   = WR_WIN;
                    busy_d    = 1'b1;
                    err_d     = 1'b0;
                    awaddr_d  = ADDR_WINDOW;
                    wdata_d   = window;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
`ifdef CCSEQ_POLL_TIMEOUT_EN
                    poll_cnt_d = '0;
`endif
                end
            end

            WR_WIN, WR_RUN: begin
                // AW and W complete independently; B is accepted only once both have.
                if (aw_fire) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_fire) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if (!bready_q && (aw_done_q || aw_fire) && (w_done_q || w_fire)) begin
                    bready_d = 1'b1;
                end
                if (b_fire) begin
                    bready_d  = 1'b0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    if (m_axi_bresp != 2'b00) begin
                        state_d = FIN;
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                    end else if (state_q == WR_WIN) begin
                        state_d   = WR_RUN;
                        awaddr_d  = ADDR_CTRL;
                        wdata_d   = 32'h0000_0001;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d    = POLL;
                        araddr_d   = ADDR_STATUS;
                        arvalid_d  = 1'b1;
                        poll_gap_d = 1'b0;
                    end
                end
            end

            POLL: begin
                // The gap flag holds off the next status read for one cycle.
                if (poll_gap_q) begin
                    poll_gap_d = 1'b0;
                    arvalid_d  = 1'b1;
                end
                if (ar_fire) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
                if (r_fire) begin
                    rready_d = 1'b0;
                    if (m_axi_rresp != 2'b00) begin
                        state_d = FIN;
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                    end else if (m_axi_rdata[0]) begin
                        state_d   = RD_CNT;
                        araddr_d  = ADDR_COUNT;
                        arvalid_d = 1'b1;
                    end else begin
                        poll_gap_d = 1'b1;
`ifdef CCSEQ_POLL_TIMEOUT_EN
                        if (poll_cnt_q == PC_LAST) begin
                            state_d    = FIN;
                            err_d      = 1'b1;
                            done_d     = 1'b1;
                            poll_gap_d = 1'b0;
                        end else begin
                            poll_cnt_d = poll_cnt_q + 1'b1;
                        end
`endif
                    end
                end
            end

            RD_CNT: begin
                if (ar_fire) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
                if (r_fire) begin
                    rready_d = 1'b0;
                    state_d  = FIN;
                    done_d   = 1'b1;
                    if (m_axi_rresp == 2'b00) begin
                        count_d = m_axi_rdata;
                        err_d   = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            FIN: begin
                // done is high for exactly this cycle.
                state_d = IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; a low ARESETN abandons any transaction in flight.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            count_q    <= '0;
            awaddr_q   <= '0;
            awvalid_q  <= 1'b0;
            wdata_q    <= '0;
            wvalid_q   <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            bready_q   <= 1'b0;
            araddr_q   <= '0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            poll_gap_q <= 1'b0;
`ifdef CCSEQ_POLL_TIMEOUT_EN
            poll_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            count_q    <= count_d;
            awaddr_q   <= awaddr_d;
            awvalid_q  <= awvalid_d;
            wdata_q    <= wdata_d;
            wvalid_q   <= wvalid_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            bready_q   <= bready_d;
            araddr_q   <= araddr_d;
            arvalid_q  <= arvalid_d;
            rready_q   <= rready_d;
            poll_gap_q <= poll_gap_d;
`ifdef CCSEQ_POLL_TIMEOUT_EN
            poll_cnt_q <= poll_cnt_d;
`endif
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign count         = count_q;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_clock_counter_sequencer.sv
// Bench for clock_counter_sequencer: an AXI4-Lite slave model of the
// clockCounter peripheral plus scoreboards of expected writes, reads and results.
`timescale 1ns/1ps

module tb_clock_counter_sequencer;

    localparam int          ADDR_W     = 32;
    localparam logic [31:0] BASE       = 32'h4000_0100;
    localparam int          POLL_LIMIT = 4;

    logic        ACLK, ARESETN, start;
    logic [31:0] window;
    logic        busy, done, err;
    logic [31:0] count;
    logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
    logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic [1:0]  m_axi_bresp, m_axi_rresp;
    logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic        m_axi_rvalid, m_axi_rready;

    clock_counter_sequencer #(
        .ADDR_W(ADDR_W), .BASE_ADDR(BASE), .POLL_LIMIT(POLL_LIMIT)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .window(window),
        .busy(busy), .done(done), .err(err), .count(count),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [31:0] window;
        int          complete_on;
        logic [31:0] count_val;
        int          aw_delay;
        int          w_delay;
        logic [1:0]  win_bresp;
        logic [1:0]  st_rresp;
        int          n_polls;
        bit          cnt_rd;
        logic [31:0] exp_count;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          aw_cyc;
        int          w_cyc;
    } wr_t;

    typedef struct {
        logic [31:0] count;
        logic        err;
    } res_t;

    wr_t         exp_wr[$];
    logic [31:0] exp_rd[$];
    res_t        exp_res[$];

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Slave configuration, set per test
    int          cfg_complete_on = 1;
    logic [31:0] cfg_count       = '0;
    int          cfg_aw_delay    = 0;
    int          cfg_w_delay     = 0;
    logic [1:0]  cfg_win_bresp   = 2'b00;
    logic [1:0]  cfg_st_rresp    = 2'b00;
    bit          cfg_block_cnt   = 1'b0;

    // Slave state
    int          aw_cyc, w_cyc, cap_aw_cyc, cap_w_cyc, status_reads;
    logic [31:0] cap_addr, cap_data, cur_raddr;
    bit          gap_chk;

    // AXI4-Lite slave model and output monitor, acting on the falling edge
    always @(negedge ACLK) begin : slave
        wr_t  wexp;
        res_t rexp;
        logic [31:0] aexp;
        if (!ARESETN) begin
            m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
            m_axi_arready = 1'b0; m_axi_rvalid = 1'b0;
            aw_cyc = 0; w_cyc = 0; gap_chk = 1'b0;
        end else begin
            // awvalid and wvalid must rise together
            if ((m_axi_awvalid || m_axi_wvalid) && aw_cyc == 0 && w_cyc == 0)
                chk("aw_w_same_cycle", {m_axi_awvalid, m_axi_wvalid}, 2'b11);
            // never a read and a write in flight together
            if (m_axi_awvalid || m_axi_wvalid || m_axi_bready)
                chk("no_concurrent_rd", {m_axi_arvalid, m_axi_rready}, 2'b00);
            if (m_axi_bready)
                chk("bready_after_aw_w", {m_axi_awvalid, m_axi_wvalid}, 2'b00);
            if (gap_chk) begin
                chk("poll_idle_gap", m_axi_arvalid, 1'b0);
                gap_chk = 1'b0;
            end

            if (m_axi_awvalid) begin
                m_axi_awready = (aw_cyc >= cfg_aw_delay);
                if (m_axi_awready) begin
                    cap_addr = m_axi_awaddr; cap_aw_cyc = aw_cyc + 1;
                end
                aw_cyc++;
            end else begin
                m_axi_awready = 1'b0; aw_cyc = 0;
            end

            if (m_axi_wvalid) begin
                m_axi_wready = (w_cyc >= cfg_w_delay);
                if (m_axi_wready) begin
                    cap_data = m_axi_wdata; cap_w_cyc = w_cyc + 1;
                end
                w_cyc++;
            end else begin
                m_axi_wready = 1'b0; w_cyc = 0;
            end

            if (m_axi_bvalid) begin
                m_axi_bvalid = 1'b0;
            end else if (m_axi_bready) begin
                m_axi_bvalid = 1'b1;
                m_axi_bresp  = (cap_addr == BASE + 32'h4) ? cfg_win_bresp : 2'b00;
                if (cap_addr == BASE) status_reads = 0;
                if (exp_wr.size() == 0) begin
                    chk("unexpected_write", cap_addr, 64'hFFFF_FFFF_FFFF);
                end else begin
                    wexp = exp_wr.pop_front();
                    $display("WRITE addr=%08h data=%08h aw_cycles=%0d w_cycles=%0d",
                             cap_addr, cap_data, cap_aw_cyc, cap_w_cyc);
                    chk("wr_addr", cap_addr, wexp.addr);
                    chk("wr_data", cap_data, wexp.data);
                    chk("awvalid_cycles", 64'(cap_aw_cyc), 64'(wexp.aw_cyc));
                    chk("wvalid_cycles", 64'(cap_w_cyc), 64'(wexp.w_cyc));
                end
            end

            if (m_axi_arvalid && !(cfg_block_cnt && m_axi_araddr == BASE + 32'h8)) begin
                m_axi_arready = 1'b1;
                cur_raddr = m_axi_araddr;
                $display("READ  addr=%08h", cur_raddr);
                if (exp_rd.size() == 0) begin
                    chk("unexpected_read", cur_raddr, 64'hFFFF_FFFF_FFFF);
                end else begin
                    aexp = exp_rd.pop_front();
                    chk("rd_addr", cur_raddr, aexp);
                end
            end else begin
                m_axi_arready = 1'b0;
            end

            if (m_axi_rvalid) begin
                m_axi_rvalid = 1'b0;
            end else if (m_axi_rready) begin
                m_axi_rvalid = 1'b1;
                if (cur_raddr == BASE + 32'hC) begin
                    status_reads++;
                    m_axi_rdata = {31'd0, status_reads >= cfg_complete_on};
                    m_axi_rresp = cfg_st_rresp;
                    gap_chk = (cfg_st_rresp == 2'b00) && (status_reads < cfg_complete_on);
                end else begin
                    m_axi_rdata = cfg_count;
                    m_axi_rresp = 2'b00;
                end
            end

            if (done) begin
                if (exp_res.size() == 0) begin
                    chk("unexpected_done", {err, count}, 64'hFFFF_FFFF_FFFF);
                end else begin
                    rexp = exp_res.pop_front();
                    $display("DONE  count=%08h err=%0b", count, err);
                    chk("done_count", count, rexp.count);
                    chk("done_err", err, rexp.err);
                end
            end
        end
    end

    task automatic push_expect(input vec_t v, input bit with_result);
        wr_t  w;
        res_t r;
        w = '{BASE + 32'h4, v.window, v.aw_delay + 1, v.w_delay + 1};
        exp_wr.push_back(w);
        if (v.win_bresp == 2'b00) begin
            w = '{BASE, 32'h1, v.aw_delay + 1, v.w_delay + 1};
            exp_wr.push_back(w);
        end
        for (int k = 0; k < v.n_polls; k++) exp_rd.push_back(BASE + 32'hC);
        if (v.cnt_rd) exp_rd.push_back(BASE + 32'h8);
        if (with_result) begin
            r = '{v.exp_count, v.exp_err};
            exp_res.push_back(r);
        end
    endtask

    task automatic configure(input vec_t v);
        cfg_complete_on = v.complete_on; cfg_count = v.count_val;
        cfg_aw_delay = v.aw_delay; cfg_w_delay = v.w_delay;
        cfg_win_bresp = v.win_bresp; cfg_st_rresp = v.st_rresp;
        status_reads = 0;
    endtask

    task automatic pulse_start(input logic [31:0] w);
        @(negedge ACLK); start = 1'b1; window = w;
        @(negedge ACLK); start = 1'b0; window = $urandom;
    endtask

    task automatic wait_done();
        int c;
        c = 0;
        while (exp_res.size() != 0 && c < 3000) begin
            @(negedge ACLK); c++;
        end
        chk("done_within_budget", 64'(exp_res.size()), 64'd0);
        exp_res.delete();
        @(negedge ACLK);
        chk("idle_after_done", busy, 1'b0);
        chk("scoreboard_drained", 64'(exp_wr.size() + exp_rd.size()), 64'd0);
        exp_wr.delete(); exp_rd.delete();
    endtask

    task automatic wait_arvalid(input logic [31:0] addr);
        int c;
        c = 0;
        while (!(m_axi_arvalid && m_axi_araddr == addr) && c < 2000) begin
            @(negedge ACLK); c++;
        end
        chk("arvalid_seen", {m_axi_arvalid, m_axi_araddr}, {1'b1, addr});
    endtask

    task automatic run_vec(input vec_t v);
        configure(v);
        push_expect(v, 1'b1);
        pulse_start(v.window);
        chk("busy_after_start", busy, 1'b1);
        wait_done();
    endtask

    vec_t vecs[5];
    vec_t v;

    initial begin
        //           window        co  count         awd wd wbr    srr    np cr exp_count     err
        vecs[0] = '{32'd100,       3, 32'h64,        0, 0, 2'b00, 2'b00, 3, 1, 32'h64,        1'b0};
        vecs[1] = '{32'h1234,      1, 32'hDEADBEEF,  3, 0, 2'b00, 2'b00, 1, 1, 32'hDEADBEEF,  1'b0};
        vecs[2] = '{32'd7,         2, 32'h55,        0, 2, 2'b10, 2'b00, 0, 0, 32'hDEADBEEF,  1'b1};
        vecs[3] = '{32'h0,         1, 32'h0,         0, 0, 2'b00, 2'b11, 1, 0, 32'hDEADBEEF,  1'b1};
        vecs[4] = '{32'hFFFFFFFF,  4, 32'hFFFFFFFF,  1, 1, 2'b00, 2'b00, 4, 1, 32'hFFFFFFFF,  1'b0};

        ARESETN = 1'b0; start = 1'b0; window = '0;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
        m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rresp = 2'b00; m_axi_rdata = '0;
        repeat (3) @(negedge ACLK);
        chk("reset_ctrl", {busy, done, err, m_axi_awvalid, m_axi_wvalid, m_axi_bready,
                           m_axi_arvalid, m_axi_rready}, 8'h00);
        chk("reset_count", count, 32'h0);
        chk("reset_addr", {m_axi_awaddr, m_axi_araddr}, 64'h0);
        chk("reset_wdata", m_axi_wdata, 32'h0);
        ARESETN = 1'b1;
        @(negedge ACLK);

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // second start during POLL must be ignored
        v = '{32'h77, 3, 32'h1234_5678, 0, 0, 2'b00, 2'b00, 3, 1, 32'h1234_5678, 1'b0};
        configure(v);
        push_expect(v, 1'b1);
        pulse_start(v.window);
        wait_arvalid(BASE + 32'hC);
        pulse_start(32'd5);
        wait_done();

        // reset while the COUNT read is waiting on arready
        v = '{32'h99, 2, 32'h4242, 0, 0, 2'b00, 2'b00, 2, 0, 32'h0, 1'b0};
        configure(v);
        cfg_block_cnt = 1'b1;
        push_expect(v, 1'b0);
        pulse_start(v.window);
        wait_arvalid(BASE + 32'h8);
        ARESETN = 1'b0;
        @(negedge ACLK);
        chk("midrst_ctrl", {busy, done, err, m_axi_awvalid, m_axi_wvalid, m_axi_bready,
                            m_axi_arvalid, m_axi_rready}, 8'h00);
        chk("midrst_count", count, 32'h0);
        chk("midrst_addr", {m_axi_awaddr, m_axi_araddr}, 64'h0);
        chk("midrst_wdata", m_axi_wdata, 32'h0);
        ARESETN = 1'b1;
        cfg_block_cnt = 1'b0;
        repeat (3) @(negedge ACLK);
        chk("midrst_no_done", done, 1'b0);
        chk("midrst_drained", 64'(exp_wr.size() + exp_rd.size()), 64'd0);
        exp_wr.delete(); exp_rd.delete();

        v = '{32'h10, 1, 32'hABC, 0, 0, 2'b00, 2'b00, 1, 1, 32'hABC, 1'b0};
        run_vec(v);

`ifdef CCSEQ_POLL_TIMEOUT_EN
        // STATUS never completes: exactly POLL_LIMIT reads, then err
        v = '{32'h20, 100000, 32'h1, 0, 0, 2'b00, 2'b00, POLL_LIMIT, 0, 32'hABC, 1'b1};
        run_vec(v);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
